instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 18 +
 rtl/instr_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and the instruction memory (slave).
interface instr_fetch_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;

   modport master (
      output imemReq, imemAddr,
      input  imemGnt, imemRvalid, imemRdata
   );

   modport slave (
      input  imemReq, imemAddr,
      output imemGnt, imemRvalid, imemRdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch FSM: IDLE -> REQ -> WAIT -> VALID, with flush/stall handling.
// Optional FETCH_MISALIGN_CHK_EN: block misaligned fetches and raise a sticky fetchMisalign flag.
module instr_fetch (
   input  logic          clk,
   input  logic          rstN,
   input  logic [31:0]   pc,
   output logic          pcAdvance,
   input  logic          flush,
   input  logic          stallIn,
   instr_fetch_if.master imem,
   output logic          instrValid,
   output logic [31:0]   instrOut,
   output logic [31:0]   instrPc,
   output logic          fetchMisalign
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] VALID = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] reqPc_q, reqPc_d;
   logic        dropPending_q, dropPending_d;
   logic [31:0] instrOut_q, instrOut_d;
   logic [31:0] instrPc_q, instrPc_d;
   logic        misalignHit;
   logic        reqOn;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;

   assign misalignHit = (state_q == REQ) && (pc[1:0] != 2'b00);

   always_comb begin
      misalign_d = misalign_q;
      if (flush)
         misalign_d = 1'b0;
      else if (misalignHit)
         misalign_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         misalign_q <= 1'b0;
      else
         misalign_q <= misalign_d;
   end

   assign fetchMisalign = misalign_q;
`else
   assign misalignHit   = 1'b0;
   assign fetchMisalign = 1'b0;
`endif

   assign instrValid = (state_q == VALID);
   assign pcAdvance  = instrValid && !stallIn && !flush;
   assign instrOut   = instrOut_q;
   assign instrPc    = instrPc_q;

   // A flushing REQ cycle withholds the request so no grant is taken for a stale address.
   assign reqOn         = (state_q == REQ) && !flush && !misalignHit;
   assign imem.imemReq  = reqOn;
   assign imem.imemAddr = {pc[31:2], 2'b00};

   always_comb begin
      state_d       = state_q;
      reqPc_d       = reqPc_q;
      dropPending_d = dropPending_q;
      instrOut_d    = instrOut_q;
      instrPc_d     = instrPc_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (reqOn && imem.imemGnt) begin
               reqPc_d = pc;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem.imemRvalid) begin
               dropPending_d = 1'b0;
               if (!flush && !dropPending_q) begin
                  instrOut_d = imem.imemRdata;
                  instrPc_d  = reqPc_q;
                  state_d    = VALID;
               end else begin
                  state_d = REQ;
               end
            end else if (flush) begin
               dropPending_d = 1'b1;
            end
         end
         VALID: begin
            if (flush || pcAdvance)
               state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q       <= IDLE;
         reqPc_q       <= 32'h0;
         dropPending_q <= 1'b0;
         instrOut_q    <= 32'h0;
         instrPc_q     <= 32'h0;
      end else begin
         state_q       <= state_d;
         reqPc_q       <= reqPc_d;
         dropPending_q <= dropPending_d;
         instrOut_q    <= instrOut_d;
         instrPc_q     <= instrPc_d;
      end
   end

endmodule
